iqsrc_prbs: RTL and testbench
=============================

// Module: iqsrc_prbs
// PURPOSE
//  PRBS-31 word source feeding the QPSK mapper's 128-bit reader interface (reader_data/reader_en).
//  Produces a programmable number of pseudo-random 128-bit words for end-to-end map/demap BER runs.
//  Sits directly upstream of iqmap_qpsk; the same PRBS model checks the demapper's writer_data.
// PARAMETERS
//  W      128  output word width (generated bits per word); must be >= 32
//  CNT_W  16   width of the word-count register / nwords port
// PORTS
//  CLK          in   1      clock, single domain
//  RST          in   1      reset, asynchronous, active-low
//  ce           in   1      clock enable; when 0 every register holds
//  start        in   1      begin a run (sampled in IDLE only)
//  seed         in   31     LFSR seed, latched on start; 0 is replaced by 31'h1
//  nwords       in   CNT_W  words to emit, latched on start
//  reader_en    in   1      consumer pops the current word
//  valid_o      out  1      reader_data holds a valid word
//  reader_data  out  W      current word; bit 0 = earliest generated bit
//  busy         out  1      run in progress (LOAD or RUN)
//  done         out  1      one-cycle pulse at end of run
// BEHAVIOUR
//  - Reset: valid_o=0, reader_data=0, busy=0, done=0, state=IDLE, lfsr=31'h1, count=0.
//  - All state updates are qualified by ce; with ce=0, outputs and state hold.
//  - LFSR step: b = s[30]^s[27]; s <= {s[29:0],b}; output bit b. One word = W consecutive steps, computed combinationally in one cycle.
//  - FSM:
//    - IDLE: start=1 -> latch seed/nwords. nwords==0 -> DONE, else LOAD.
//    - LOAD: reader_data <= next word from seed; valid_o <= 1 -> RUN. The first word is visible 2 ce-cycles after start.
//    - RUN: transfer = valid_o & reader_en. On transfer: count+1. If count+1==nwords, valid_o <= 0 -> DONE; else the next word loads the same cycle (no bubble, one word per cycle possible). No transfer: data/valid hold.
//    - DONE: done=1 for one ce-cycle -> IDLE.
//  - busy=1 in LOAD and RUN. start outside IDLE is ignored; parameters are not re-latched.
//  - reader_data is unchanged after the final transfer (stale, valid_o=0).
//  - reader_en with valid_o=0 is ignored and has no side effects.
//  - Async reset mid-run: immediate return to reset values; no done pulse.
//  - count wraps never: the run ends at nwords; max run 2^CNT_W-1 words.
// CONFIGURATION
//  IQSRC_ERRINJ_EN defined:
//    - adds input err_inj (1 bit).
//    - A pulse while busy arms a one-shot: the next word loaded into reader_data has bit 0 inverted.
//    - LFSR sequence unaffected; the flag clears once applied; pulses while armed merge.
//  IQSRC_ERRINJ_EN undefined: no err_inj port; words are always pure PRBS.
// TESTING
//  - reset; seed=1, nwords=1, start; reader_en=1 -> valid_o high 2 cycles after start; reader_data[31:0]=32'h4800_0000; done pulses 1 cycle after the transfer.
//  - seed=0 -> output identical to seed=1.
//  - nwords=8, reader_en=1 constant -> 8 back-to-back valid cycles matching the model; busy high from LOAD through the last transfer; one done pulse.
//  - nwords=4, reader_en toggling 1,0,0,1,... and ce low every 3rd cycle -> word held while stalled; exactly 4 transfers; words equal to the model in order.
//  - nwords=0 -> no valid_o; done pulses the cycle after start; start during RUN -> ignored, count unchanged.
//  - RST low mid-run (after word 2 of 5) -> outputs reset asynchronously, no done; a new start with the same seed repeats word 1.
//  - With IQSRC_ERRINJ_EN: err_inj during RUN -> next word differs from the model only in bit 0; following words are clean.

Source files
------------

// File: rtl/iqsrc_prbs.sv
// PRBS-31 word source for the QPSK mapper reader interface: emits nwords W-bit words per run.
// Optional one-shot bit-0 error injection is enabled with the IQSRC_ERRINJ_EN macro.
module iqsrc_prbs #(
    parameter int W     = 128,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ce,
    input  logic             start,
    input  logic [30:0]      seed,
    input  logic [CNT_W-1:0] nwords,
    input  logic             reader_en,
`ifdef IQSRC_ERRINJ_EN
    input  logic             err_inj,
`endif
    output logic             valid_o,
    output logic [W-1:0]     reader_data,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [30:0]      r_lfsr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_nwords;
    logic             r_valid;
    logic [W-1:0]     r_data;

    logic             w_latch;
    logic             w_load;
    logic             w_xfer;
    logic             w_last;
    logic             w_flip;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [W+30:0]    w_gen;
    logic [W-1:0]     w_word;
    logic [30:0]      w_lfsr_nxt;

    // W consecutive LFSR steps unrolled into one cycle; returns {next state, word}.
    function automatic logic [W+30:0] prbs_word(input logic [30:0] s_in);
        logic [30:0]  s;
        logic [W-1:0] wd;
        logic         b;
        s  = s_in;
        wd = '0;
        for (int i = 0; i < W; i++) begin
            b     = s[30] ^ s[27];
            wd[i] = b;
            s     = {s[29:0], b};
        end
        return {s, wd};
    endfunction

    assign w_gen      = prbs_word(r_lfsr);
    assign w_word     = w_gen[W-1:0];
    assign w_lfsr_nxt = w_gen[W+30:W];
    assign w_cnt_inc  = r_count + CNT_W'(1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else if (ce) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_load      = 1'b0;
        w_xfer      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_latch     = 1'b1;
                    w_state_nxt = (nwords == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (r_valid && reader_en) begin
                    w_xfer = 1'b1;
                    if (w_cnt_inc == r_nwords) begin
                        w_last      = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        // Back-to-back: the replacement word loads on the same edge as the pop.
                        w_load = 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef IQSRC_ERRINJ_EN
    logic r_err_arm;

    // Pulses while already armed merge into the single pending flip.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_err_arm <= 1'b0;
        end else if (ce) begin
            r_err_arm <= (r_err_arm & ~w_load) | (err_inj & busy);
        end
    end

    assign w_flip = r_err_arm;
`else
    assign w_flip = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_lfsr   <= 31'h1;
            r_count  <= '0;
            r_nwords <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
        end else if (ce) begin
            if (w_latch) begin
                r_lfsr   <= (seed == 31'h0) ? 31'h1 : seed;
                r_nwords <= nwords;
                r_count  <= '0;
            end
            if (w_xfer) begin
                r_count <= w_cnt_inc;
            end
            if (w_load) begin
                r_data  <= {w_word[W-1:1], w_word[0] ^ w_flip};
                r_lfsr  <= w_lfsr_nxt;
                r_valid <= 1'b1;
            end else if (w_last) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign valid_o     = r_valid;
    assign reader_data = r_data;
    assign busy        = (r_state == S_LOAD) || (r_state == S_RUN);
    assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_iqsrc_prbs.sv
// Directed self-checking bench for iqsrc_prbs; covers IQSRC_ERRINJ_EN when that macro is defined.
module tb_iqsrc_prbs;

    localparam int W     = 128;
    localparam int CNT_W = 16;

    logic             CLK;
    logic             RST;
    logic             ce;
    logic             start;
    logic [30:0]      seed;
    logic [CNT_W-1:0] nwords;
    logic             reader_en;
    logic             valid_o;
    logic [W-1:0]     reader_data;
    logic             busy;
    logic             done;
`ifdef IQSRC_ERRINJ_EN
    logic             err_inj;
`endif

    int nerr;
    int nchk;

    iqsrc_prbs #(.W(W), .CNT_W(CNT_W)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ce          (ce),
        .start       (start),
        .seed        (seed),
        .nwords      (nwords),
        .reader_en   (reader_en),
`ifdef IQSRC_ERRINJ_EN
        .err_inj     (err_inj),
`endif
        .valid_o     (valid_o),
        .reader_data (reader_data),
        .busy        (busy),
        .done        (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: word k (0-based) of a run started from seed sd.
    function automatic logic [W-1:0] mword(input logic [30:0] sd, input int k);
        logic [30:0]  s;
        logic [W-1:0] wd;
        logic         b;
        s  = (sd == 31'h0) ? 31'h1 : sd;
        wd = '0;
        for (int n = 0; n <= k; n++) begin
            for (int i = 0; i < W; i++) begin
                b     = s[30] ^ s[27];
                wd[i] = b;
                s     = {s[29:0], b};
            end
        end
        return wd;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_start(input logic [30:0] sd, input logic [CNT_W-1:0] n);
        seed   = sd;
        nwords = n;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    initial begin
        logic [W-1:0] prev_data;
        logic [W-1:0] w0;
        logic         prev_valid;
        logic         prev_done;
        logic         last_xfer;
        int           ntr;
        int           ndone;

        nerr      = 0;
        nchk      = 0;
        RST       = 1'b0;
        ce        = 1'b1;
        start     = 1'b0;
        seed      = '0;
        nwords    = '0;
        reader_en = 1'b0;
`ifdef IQSRC_ERRINJ_EN
        err_inj   = 1'b0;
`endif
        tick();
        tick();
        chk("rst_valid", valid_o, 0);
        chk("rst_data", reader_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        RST = 1'b1;
        tick();

        // Single word from seed 1: first 32 bits hand-computed as 32'h4800_0000.
        reader_en = 1'b1;
        do_start(31'h1, 16'd1);
        chk("t1_load_valid", valid_o, 0);
        chk("t1_load_busy", busy, 1);
        tick();
        chk("t1_valid", valid_o, 1);
        chk("t1_word32", {96'h0, reader_data[31:0]}, {96'h0, 32'h4800_0000});
        chk("t1_word", reader_data, mword(31'h1, 0));
        w0 = reader_data;
        tick();
        chk("t1_done", done, 1);
        chk("t1_valid_off", valid_o, 0);
        chk("t1_busy_off", busy, 0);
        chk("t1_stale", reader_data, w0);
        tick();
        chk("t1_done_clr", done, 0);

        // Seed 0 behaves as seed 1.
        do_start(31'h0, 16'd1);
        tick();
        chk("seed0_word", reader_data, w0);
        tick();
        tick();

        // Eight back-to-back words.
        do_start(31'h1234567, 16'd8);
        chk("b2b_busy_load", busy, 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("b2b_valid%0d", i), valid_o, 1);
            chk($sformatf("b2b_busy%0d", i), busy, 1);
            chk($sformatf("b2b_word%0d", i), reader_data, mword(31'h1234567, i));
        end
        tick();
        chk("b2b_done", done, 1);
        chk("b2b_valid_off", valid_o, 0);
        tick();
        chk("b2b_done_clr", done, 0);

        // Stalls from reader_en and ce; every pop compared in order.
        reader_en = 1'b0;
        do_start(31'h5A5A5A5, 16'd4);
        ntr        = 0;
        ndone      = 0;
        prev_valid = 1'b0;
        prev_done  = 1'b0;
        prev_data  = '0;
        last_xfer  = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            ce        = (cyc % 3) != 2;
            reader_en = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            if (prev_valid && !last_xfer) begin
                chk("stall_hold_valid", valid_o, 1);
                chk("stall_hold_data", reader_data, prev_data);
            end
            if (done && !prev_done) ndone++;
            last_xfer = valid_o && reader_en && ce;
            if (last_xfer) begin
                chk($sformatf("stall_word%0d", ntr), reader_data, mword(31'h5A5A5A5, ntr));
                ntr++;
            end
            prev_valid = valid_o;
            prev_done  = done;
            prev_data  = reader_data;
            tick();
        end
        ce        = 1'b1;
        reader_en = 1'b0;
        chk("stall_ntransfers", ntr, 4);
        chk("stall_ndone", ndone, 1);
        chk("stall_valid_end", valid_o, 0);

        // Zero-length run.
        do_start(31'h77, 16'd0);
        chk("zero_valid", valid_o, 0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        tick();
        chk("zero_done_clr", done, 0);

        // start during RUN must not re-latch seed or count.
        do_start(31'h0ABCDEF, 16'd3);
        tick();
        chk("restart_w0", reader_data, mword(31'h0ABCDEF, 0));
        do_start(31'h1111, 16'd1);
        chk("restart_valid", valid_o, 1);
        chk("restart_hold", reader_data, mword(31'h0ABCDEF, 0));
        reader_en = 1'b1;
        tick();
        chk("restart_w1", reader_data, mword(31'h0ABCDEF, 1));
        tick();
        chk("restart_w2", reader_data, mword(31'h0ABCDEF, 2));
        chk("restart_valid2", valid_o, 1);
        tick();
        chk("restart_done", done, 1);
        reader_en = 1'b0;
        tick();

        // Asynchronous reset after the second of five words.
        reader_en = 1'b1;
        do_start(31'h2468ACE, 16'd5);
        tick();
        tick();
        tick();
        chk("arst_pre_word", reader_data, mword(31'h2468ACE, 2));
        #2 RST = 1'b0;
        #1;
        chk("arst_valid", valid_o, 0);
        chk("arst_data", reader_data, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        tick();
        chk("arst_done_held", done, 0);
        RST = 1'b1;
        tick();
        do_start(31'h2468ACE, 16'd1);
        tick();
        chk("arst_again_w0", reader_data, mword(31'h2468ACE, 0));
        tick();
        chk("arst_again_done", done, 1);
        reader_en = 1'b0;
        tick();

`ifdef IQSRC_ERRINJ_EN
        // One-shot bit-0 flip on the next loaded word; later words clean.
        do_start(31'h13579B, 16'd3);
        tick();
        chk("inj_w0", reader_data, mword(31'h13579B, 0));
        err_inj = 1'b1;
        tick();
        err_inj = 1'b0;
        chk("inj_w0_hold", reader_data, mword(31'h13579B, 0));
        reader_en = 1'b1;
        tick();
        chk("inj_w1", reader_data, mword(31'h13579B, 1) ^ {{(W-1){1'b0}}, 1'b1});
        tick();
        chk("inj_w2", reader_data, mword(31'h13579B, 2));
        tick();
        reader_en = 1'b0;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
